// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared encodings for the HI/LO multiply sequencer
//
// Purpose: op and state encodings plus iteration-count helpers used by
// hilo_muldiv_sequencer.
// Ports: none (package).

package hilo_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int ITER_LAST  = HILO_WIDTH - 1;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Counter value seen at the edge that performs the final iteration.
  function automatic int iter_last(input int iters);
    return iters - 1;
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_step.sv
// rtl/hilo_muldiv_sequencer_step.sv - one combinational radix-2 shift-add iteration
//
// Purpose: conditionally adds the multiplicand into the upper half of the
// product accumulator, then shifts accumulator and multiplier right by one.
// Ports:
//   i_acc    2*WIDTH  current accumulator
//   i_mcand  WIDTH    multiplicand (unsigned magnitude)
//   i_mplr   WIDTH    remaining multiplier bits, LSB consumed this step
//   o_acc    2*WIDTH  accumulator after add and shift
//   o_mplr   WIDTH    multiplier after shift

module shift_add_mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplr,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_mplr
);

  logic [WIDTH:0] w_sum;

  // The carry out of the upper-half add becomes the new accumulator MSB
  // after the shift, so no product bit is ever lost.
  always_comb begin
    w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
    if (i_mplr[0]) begin
      w_sum = w_sum + {1'b0, i_mcand};
    end
  end

  assign o_acc  = {w_sum, i_acc[WIDTH-1:1]};
  assign o_mplr = {1'b0, i_mplr[WIDTH-1:1]};

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// rtl/hilo_muldiv_sequencer.sv - iterative HI/LO multiply/accumulate sequencer
//
// Purpose: owns HI/LO and executes MULT, MULTU, MADD, MSUB (33-cycle
// shift-add) and MTHI/MTLO (single edge); requests a stall when MFHI/MFLO
// would read HI/LO while a product is in flight.
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   synchronous active-high reset
//   Start     in   issue strobe
//   Op        in   3-bit operation code
//   A, B      in   rs / rt operands
//   ReadHiLo  in   MFHI/MFLO present in EX
//   Hi, Lo    out  architectural HI / LO
//   Busy      out  product in flight
//   Done      out  one-cycle pulse after a product updates HI/LO
//   Stall     out  pipeline hold request

module hilo_muldiv_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(iter_last(ITER));

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2:0]         r_op;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic               r_done;

  logic               w_mul_op;
  logic               w_signed_op;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_mplr_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo_nxt;

  assign w_mul_op    = (Op == OP_MULT) || (Op == OP_MULTU) ||
                       (Op == OP_MADD) || (Op == OP_MSUB);
  assign w_signed_op = w_mul_op && (Op != OP_MULTU);

  // Negating the most negative value wraps to itself, which read as
  // unsigned is exactly its magnitude.
  assign w_a_mag = A[WIDTH-1] ? -A : A;
  assign w_b_mag = B[WIDTH-1] ? -B : B;

  shift_add_mul_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_mplr  (r_mplr),
    .o_acc   (w_acc_nxt),
    .o_mplr  (w_mplr_nxt)
  );

  // r_neg is only ever set for signed ops, so MULTU passes straight through.
  assign w_prod = r_neg ? -r_acc : r_acc;

  always_comb begin
    w_hilo_nxt = w_prod;
    case (r_op)
      OP_MADD: w_hilo_nxt = {r_hi, r_lo} + w_prod;
      OP_MSUB: w_hilo_nxt = {r_hi, r_lo} - w_prod;
      default: w_hilo_nxt = w_prod;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start && w_mul_op) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start && w_mul_op) begin
            r_op    <= Op;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mcand <= w_signed_op ? w_a_mag : A;
            r_mplr  <= w_signed_op ? w_b_mag : B;
            r_neg   <= w_signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
          end else if (Start && (Op == OP_MTHI)) begin
            r_hi <= A;
          end else if (Start && (Op == OP_MTLO)) begin
            r_lo <= A;
          end
        end
        S_MUL: begin
          r_acc  <= w_acc_nxt;
          r_mplr <= w_mplr_nxt;
          r_cnt  <= r_cnt + 1'b1;
        end
        S_FIX: begin
          {r_hi, r_lo} <= w_hilo_nxt;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Hi    = r_hi;
  assign Lo    = r_lo;
  assign Busy  = (r_state != S_IDLE);
  assign Done  = r_done;
  assign Stall = ReadHiLo & Busy;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb/tb_hilo_muldiv_sequencer.sv - self-checking bench for hilo_muldiv_sequencer

module tb_hilo_muldiv_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        ReadHiLo;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        Stall;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_hilo;

  hilo_muldiv_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .ReadHiLo (ReadHiLo),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done),
    .Stall    (Stall)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (op == 3'd1) return {32'b0, a} * {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    return 64'(sa * sb);
  endfunction

  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0, 3'd1: m_hilo = ref_prod(op, a, b);
      3'd2:       m_hilo = m_hilo + ref_prod(op, a, b);
      3'd3:       m_hilo = m_hilo - ref_prod(op, a, b);
      3'd4:       m_hilo[63:32] = a;
      3'd5:       m_hilo[31:0] = a;
      default: ;
    endcase
  endfunction

  // Present one instruction for a single edge, then scramble the operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    model_apply(op, a, b);
    tick();
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Runs from the first busy cycle to the Done cycle; optionally tries a
  // stray MULT 9*9 at busy cycle 'inject'.
  task automatic wait_done(input string tag, input int inject);
    int n = 0;
    while (Busy === 1'b1 && n < 60) begin
      check_eq({tag, "/stall_done_busy"}, {62'b0, Stall, Done}, {62'b0, ReadHiLo, 1'b0});
      n++;
      if (n == inject) begin
        Start = 1'b1;
        Op    = 3'd0;
        A     = 32'd9;
        B     = 32'd9;
      end
      tick();
      Start = 1'b0;
    end
    check_eq({tag, "/busy_cycles"}, 64'(n), 64'd33);
    check_eq({tag, "/done"}, {63'b0, Done}, 64'd1);
    check_eq({tag, "/stall_at_done"}, {63'b0, Stall}, 64'd0);
    check_eq({tag, "/hilo"}, {Hi, Lo}, m_hilo);
  endtask

  task automatic after_done(input string tag);
    tick();
    check_eq({tag, "/done_one_cycle"}, {63'b0, Done}, 64'd0);
  endtask

  initial begin
    bit saw_done;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    Reset    = 1'b1;
    Start    = 1'b0;
    Op       = 3'd0;
    A        = '0;
    B        = '0;
    ReadHiLo = 1'b0;
    m_hilo   = '0;
    tick();
    tick();
    Reset = 1'b0;
    check_eq("reset/hilo", {Hi, Lo}, 64'd0);
    check_eq("reset/busy_done", {62'b0, Busy, Done}, 64'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 0);
    check_eq("multu_max/const", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    after_done("multu_max");

    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 0);
    check_eq("mult_neg/const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    after_done("mult_neg");

    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", 0);
    check_eq("mult_min/const", {Hi, Lo}, 64'h4000_0000_0000_0000);
    after_done("mult_min");

    issue(3'd4, 32'd1, 32'd0);
    check_eq("mthi/hi", {32'b0, Hi}, 64'd1);
    check_eq("mthi/busy_done", {62'b0, Busy, Done}, 64'd0);
    issue(3'd5, 32'd0, 32'd0);
    check_eq("mtlo/lo", {32'b0, Lo}, 64'd0);
    issue(3'd2, 32'd2, 32'd3);
    wait_done("madd", 0);
    check_eq("madd/const", {Hi, Lo}, 64'h0000_0001_0000_0006);
    after_done("madd");
    issue(3'd3, 32'd1, 32'd7);
    wait_done("msub", 0);
    check_eq("msub/const", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
    after_done("msub");

    ReadHiLo = 1'b1;
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done("stall_inject", 10);
    after_done("stall_inject");
    ReadHiLo = 1'b0;

    issue(3'd5, 32'h55, 32'd0);
    check_eq("mtlo55/lo", {32'b0, Lo}, 64'h55);
    issue(3'd1, 32'd5, 32'd5);
    for (int i = 0; i < 10; i++) tick();
    Reset = 1'b1;
    tick();
    Reset  = 1'b0;
    m_hilo = '0;
    check_eq("abort/hilo", {Hi, Lo}, 64'd0);
    check_eq("abort/busy_done", {62'b0, Busy, Done}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check_eq("abort/no_done", {63'b0, saw_done}, 64'd0);

    issue(3'd1, 32'd2, 32'd2);
    wait_done("b2b_first", 0);
    issue(3'd0, 32'd4, 32'd4);
    wait_done("b2b_second", 0);
    check_eq("b2b_second/lo", {32'b0, Lo}, 64'd16);
    after_done("b2b_second");

    for (int k = 0; k < 10; k++) begin
      rop      = 3'($urandom_range(0, 7));
      ra       = (k == 3) ? 32'h8000_0000 : 32'($urandom);
      rb       = (k == 5) ? 32'hFFFF_FFFF : 32'($urandom);
      ReadHiLo = 1'($urandom_range(0, 1));
      issue(rop, ra, rb);
      if (rop <= 3'd3) begin
        wait_done($sformatf("rand%0d_op%0d", k, rop), 0);
        after_done($sformatf("rand%0d", k));
      end else begin
        check_eq($sformatf("rand%0d_op%0d/hilo", k, rop), {Hi, Lo}, m_hilo);
        check_eq($sformatf("rand%0d_op%0d/busy", k, rop), {63'b0, Busy}, 64'd0);
      end
    end
    ReadHiLo = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
